// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmit arbiter slice.
package serial_pkg;

   localparam int unsigned BYTE_W      = 8;
   localparam int unsigned DEF_TIMEOUT = 1023;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_t;

endpackage

// File: rtl/serial_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester above last_grant, wrapping modulo NREQ.
module rr_pick #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned LGW  = 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [LGW-1:0]  last_grant,
   output logic [NREQ-1:0] pick,
   output logic            any_req
);

   logic found;

   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i == (32'(last_grant) + k) % NREQ)) begin
               pick[i] = 1'b1;
               found   = 1'b1;
            end
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/serial_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the serial transmitter write port,
// with a stall watchdog that revokes a grant held by a dead requester.
module serial_tx_arbiter
   import serial_pkg::*;
#(
   parameter int unsigned NREQ    = 2,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT,
   parameter int unsigned TW      = 10
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ-1:0]        req_last,
   input  logic [BYTE_W*NREQ-1:0] req_data,
   output logic [NREQ-1:0]        req_ready,
   input  logic                   tx_full,
   output logic                   xmit,
   output logic [BYTE_W-1:0]      txchar,
   output logic [NREQ-1:0]        grant,
   output logic                   busy,
   output logic                   timeout_err,
   input  logic                   err_clr
);

   localparam int unsigned    LGW       = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [LGW-1:0] LG_RESET  = LGW'(NREQ - 1);
   // Revocation lands on the cycle after the TIMEOUT-th stalled cycle.
   localparam logic [TW-1:0]  STALL_MAX = TW'(TIMEOUT - 1);

   state_t            state;
   logic [LGW-1:0]    last_grant;
   logic [LGW-1:0]    owner;
   logic [TW-1:0]     stall;
   logic [NREQ-1:0]   pick;
   logic              any_req;
   logic              hs;
   logic              hs_last;
   logic [BYTE_W-1:0] sel_data;

   rr_pick #(
      .NREQ (NREQ),
      .LGW  (LGW)
   ) u_pick (
      .req        (req_valid),
      .last_grant (last_grant),
      .pick       (pick),
      .any_req    (any_req)
   );

   // Blocking on xmit spaces writes two cycles apart so tx_full is current for each one.
   always_comb begin
      req_ready = '0;
      if (state == ST_XFER && !tx_full && !xmit)
         req_ready = grant;
   end

   assign hs      = |(req_valid & req_ready);
   assign hs_last = |(req_valid & req_ready & req_last);

   always_comb begin
      owner    = '0;
      sel_data = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            owner    = LGW'(i);
            sel_data = req_data[i*BYTE_W +: BYTE_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         grant       <= '0;
         xmit        <= 1'b0;
         txchar      <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         last_grant  <= LG_RESET;
         stall       <= '0;
      end else begin
         xmit <= 1'b0;
         if (err_clr)
            timeout_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  state <= ST_XFER;
                  grant <= pick;
                  busy  <= 1'b1;
                  stall <= '0;
               end
            end
            ST_XFER: begin
               if (hs) begin
                  xmit   <= 1'b1;
                  txchar <= sel_data;
                  stall  <= '0;
                  if (hs_last) begin
                     state      <= ST_IDLE;
                     grant      <= '0;
                     busy       <= 1'b0;
                     last_grant <= owner;
                  end
               end else if (stall == STALL_MAX) begin
                  state       <= ST_IDLE;
                  grant       <= '0;
                  busy        <= 1'b0;
                  timeout_err <= 1'b1;
                  last_grant  <= owner;
                  stall       <= '0;
               end else begin
                  stall <= stall + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Scoreboard bench: sources push expected bytes, monitors pop and compare on every xmit.
module tb_serial_tx_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  req_valid = '0;
   logic [1:0]  req_last = '0;
   logic [15:0] req_data = '0;
   logic [1:0]  req_ready;
   logic        tx_full = 1'b0;
   logic        xmit;
   logic [7:0]  txchar;
   logic [1:0]  grant;
   logic        busy;
   logic        timeout_err;
   logic        err_clr = 1'b0;

   logic        reset3 = 1'b1;
   logic [2:0]  req_valid3 = '0;
   logic [2:0]  req_last3 = '0;
   logic [23:0] req_data3 = '0;
   logic [2:0]  req_ready3;
   logic        tx_full3 = 1'b0;
   logic        xmit3;
   logic [7:0]  txchar3;
   logic [2:0]  grant3;
   logic        busy3;
   logic        timeout_err3;
   logic        err_clr3 = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   logic [8:0] sq0[$];
   logic [8:0] sq1[$];
   logic [8:0] exp_q[$];
   logic [7:0] exp3[$];

   always #5 clk = ~clk;

   serial_tx_arbiter #(.NREQ(2), .TIMEOUT(15), .TW(4)) u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last),
      .req_data(req_data), .req_ready(req_ready), .tx_full(tx_full), .xmit(xmit),
      .txchar(txchar), .grant(grant), .busy(busy), .timeout_err(timeout_err),
      .err_clr(err_clr)
   );

   serial_tx_arbiter #(.NREQ(3)) u_dut3 (
      .clk(clk), .reset(reset3), .req_valid(req_valid3), .req_last(req_last3),
      .req_data(req_data3), .req_ready(req_ready3), .tx_full(tx_full3), .xmit(xmit3),
      .txchar(txchar3), .grant(grant3), .busy(busy3), .timeout_err(timeout_err3),
      .err_clr(err_clr3)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Main thread acts 2 time units after each falling edge.
   task automatic tick;
      @(negedge clk);
      #2;
   endtask

   task automatic drain_a(input string name);
      logic done;
      done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
         tick;
         done = (sq0.size() == 0 && sq1.size() == 0 && exp_q.size() == 0 && grant == 2'b00);
      end
      check(name, {31'd0, done}, 32'd1);
   endtask

   task automatic send3(input int idx, input logic [7:0] d, input logic l);
      logic ok;
      ok = 1'b0;
      req_valid3 = '0;
      req_valid3[idx] = 1'b1;
      req_data3[idx*8 +: 8] = d;
      req_last3 = '0;
      req_last3[idx] = l;
      for (int k = 0; k < 50 && !ok; k++) begin
         #1;
         if (req_ready3[idx]) begin
            ok = 1'b1;
            exp3.push_back(d);
         end
         tick;
      end
      check("send3_accept", {31'd0, ok}, 32'd1);
   endtask

   // Byte sources for the 2-requester DUT: present at the falling edge, retire on handshake.
   initial begin
      forever begin
         @(negedge clk);
         if (sq0.size() != 0) begin
            req_valid[0] = 1'b1;
            {req_last[0], req_data[7:0]} = sq0[0];
         end else begin
            req_valid[0] = 1'b0;
            req_last[0]  = 1'b0;
         end
         if (sq1.size() != 0) begin
            req_valid[1] = 1'b1;
            {req_last[1], req_data[15:8]} = sq1[0];
         end else begin
            req_valid[1] = 1'b0;
            req_last[1]  = 1'b0;
         end
         #3;
         if (req_valid[0] && req_ready[0] && sq0.size() != 0) void'(sq0.pop_front());
         if (req_valid[1] && req_ready[1] && sq1.size() != 0) void'(sq1.pop_front());
      end
   end

   initial begin : mon_a
      logic       owner;
      logic       prev_x;
      logic [8:0] e;
      owner  = 1'b0;
      prev_x = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (grant == 2'b01) owner = 1'b0;
         else if (grant == 2'b10) owner = 1'b1;
         if (xmit) begin
            check("xmit_gap", {31'd0, prev_x}, 32'd0);
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_xmit: got txchar 0x%0h, expected no byte", txchar);
            end else begin
               e = exp_q.pop_front();
               check("txchar", {24'd0, txchar}, {24'd0, e[7:0]});
               check("tx_src", {31'd0, owner}, {31'd0, e[8]});
            end
         end
         prev_x = xmit;
      end
   end

   initial begin : mon_3
      logic prev_x;
      prev_x = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (xmit3) begin
            check("xmit3_gap", {31'd0, prev_x}, 32'd0);
            if (exp3.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_xmit3: got txchar 0x%0h, expected no byte", txchar3);
            end else begin
               check("txchar3", {24'd0, txchar3}, {24'd0, exp3.pop_front()});
            end
         end
         prev_x = xmit3;
      end
   end

   initial begin : main
      logic [7:0] t1_gnt;
      logic [7:0] t1_x;
      logic [1:0] prev_g;
      logic [1:0] gseq[$];
      logic       done;
      int         bad;
      t1_gnt = 8'b0011_1110;
      t1_x   = 8'b0101_0100;

      tick;
      tick;
      check("rst_grant", {30'd0, grant}, 32'd0);
      check("rst_xmit", {31'd0, xmit}, 32'd0);
      check("rst_txchar", {24'd0, txchar}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_terr", {31'd0, timeout_err}, 32'd0);
      check("rst_ready", {30'd0, req_ready}, 32'd0);
      reset  = 1'b0;
      reset3 = 1'b0;

      // Single packet from requester 0
      sq0.push_back({1'b0, 8'h41}); sq0.push_back({1'b0, 8'h42}); sq0.push_back({1'b1, 8'h43});
      exp_q.push_back({1'b0, 8'h41}); exp_q.push_back({1'b0, 8'h42}); exp_q.push_back({1'b0, 8'h43});
      for (int k = 0; k < 8; k++) begin
         tick;
         check("t1_grant", {30'd0, grant}, t1_gnt[k] ? 32'd1 : 32'd0);
         check("t1_xmit", {31'd0, xmit}, {31'd0, t1_x[k]});
      end

      // Fairness: both requesters streaming 2-byte packets
      reset = 1'b1;
      tick;
      reset = 1'b0;
      sq0.push_back({1'b0, 8'hA0}); sq0.push_back({1'b1, 8'hA1});
      sq0.push_back({1'b0, 8'hA2}); sq0.push_back({1'b1, 8'hA3});
      sq1.push_back({1'b0, 8'hB0}); sq1.push_back({1'b1, 8'hB1});
      sq1.push_back({1'b0, 8'hB2}); sq1.push_back({1'b1, 8'hB3});
      exp_q.push_back({1'b0, 8'hA0}); exp_q.push_back({1'b0, 8'hA1});
      exp_q.push_back({1'b1, 8'hB0}); exp_q.push_back({1'b1, 8'hB1});
      exp_q.push_back({1'b0, 8'hA2}); exp_q.push_back({1'b0, 8'hA3});
      exp_q.push_back({1'b1, 8'hB2}); exp_q.push_back({1'b1, 8'hB3});
      prev_g = 2'b00;
      done   = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
         tick;
         if (grant != 2'b00 && prev_g == 2'b00) gseq.push_back(grant);
         prev_g = grant;
         done = (sq0.size() == 0 && sq1.size() == 0 && exp_q.size() == 0 && grant == 2'b00);
      end
      check("t2_drain", {31'd0, done}, 32'd1);
      check("t2_npkts", gseq.size(), 32'd4);
      for (int i = 0; i < gseq.size() && i < 4; i++)
         check("t2_order", {30'd0, gseq[i]}, (i % 2 == 0) ? 32'd1 : 32'd2);

      // Watchdog: owner 0 stalls after one byte, requester 1 waiting
      sq0.push_back({1'b0, 8'h55});
      sq1.push_back({1'b1, 8'h66});
      exp_q.push_back({1'b0, 8'h55});
      exp_q.push_back({1'b1, 8'h66});
      tick;
      check("t3_k0_grant", {30'd0, grant}, 32'd0);
      repeat (15) tick;
      tick;
      check("t3_k16_grant", {30'd0, grant}, 32'd1);
      check("t3_k16_terr", {31'd0, timeout_err}, 32'd0);
      tick;
      check("t3_revoke", {30'd0, grant}, 32'd0);
      check("t3_terr", {31'd0, timeout_err}, 32'd1);
      check("t3_busy", {31'd0, busy}, 32'd0);
      tick;
      check("t3_next_owner", {30'd0, grant}, 32'd2);
      drain_a("t3_drain");
      check("t3_sticky", {31'd0, timeout_err}, 32'd1);
      err_clr = 1'b1;
      tick;
      err_clr = 1'b0;
      check("t3_clear", {31'd0, timeout_err}, 32'd0);

      // Timeout coinciding with err_clr: set wins
      sq0.push_back({1'b0, 8'h77});
      exp_q.push_back({1'b0, 8'h77});
      tick;
      repeat (15) tick;
      tick;
      check("t3b_k16_terr", {31'd0, timeout_err}, 32'd0);
      check("t3b_k16_grant", {30'd0, grant}, 32'd1);
      err_clr = 1'b1;
      tick;
      err_clr = 1'b0;
      check("t3b_revoke", {30'd0, grant}, 32'd0);
      check("t3b_set_wins", {31'd0, timeout_err}, 32'd1);
      tick;
      check("t3b_held", {31'd0, timeout_err}, 32'd1);
      drain_a("t3b_drain");

      // Reset mid-packet
      sq0.push_back({1'b0, 8'h11}); sq0.push_back({1'b0, 8'h22}); sq0.push_back({1'b1, 8'h33});
      exp_q.push_back({1'b0, 8'h11});
      tick;
      tick;
      check("t4_grant", {30'd0, grant}, 32'd1);
      tick;
      check("t4_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      sq0.delete();
      tick;
      reset = 1'b0;
      check("t4_rst_grant", {30'd0, grant}, 32'd0);
      check("t4_rst_xmit", {31'd0, xmit}, 32'd0);
      check("t4_rst_busy", {31'd0, busy}, 32'd0);
      check("t4_rst_terr", {31'd0, timeout_err}, 32'd0);
      sq0.push_back({1'b1, 8'h99});
      sq1.push_back({1'b1, 8'h88});
      exp_q.push_back({1'b0, 8'h99});
      exp_q.push_back({1'b1, 8'h88});
      tick;
      tick;
      check("t4_first_pick", {30'd0, grant}, 32'd1);
      drain_a("t4_drain");

      // NREQ=3: wrap from last_grant=2 to requester 1
      check("t5_idle_grant", {29'd0, grant3}, 32'd0);
      check("t5_idle_busy", {31'd0, busy3}, 32'd0);
      req_valid3 = 3'b010;
      req_data3[15:8] = 8'hC1;
      req_last3 = 3'b010;
      tick;
      check("t5_wrap_grant", {29'd0, grant3}, 32'd2);
      check("t5_wrap_busy", {31'd0, busy3}, 32'd1);
      send3(1, 8'hC1, 1'b1);
      req_valid3 = 3'b101;
      req_data3[7:0] = 8'hE0;
      req_data3[23:16] = 8'hD0;
      req_last3 = 3'b000;
      tick;
      check("t5_rr_grant", {29'd0, grant3}, 32'd4);

      // Backpressure on requester 2
      send3(2, 8'hD0, 1'b0);
      tx_full3 = 1'b1;
      req_data3[23:16] = 8'hD1;
      for (int k = 0; k < 20; k++) begin
         tick;
         check("t6_bp_xmit", {31'd0, xmit3}, 32'd0);
         #1;
         check("t6_bp_ready", {29'd0, req_ready3}, 32'd0);
      end
      tick;
      tx_full3 = 1'b0;
      send3(2, 8'hD1, 1'b0);
      send3(2, 8'hD2, 1'b1);
      req_valid3 = '0;
      req_last3  = '0;
      tick;

      // No requests: stays idle without strobes
      bad = 0;
      repeat (30) begin
         tick;
         if (grant3 != 3'b000 || xmit3) bad++;
      end
      check("t7_idle", bad, 32'd0);
      check("t7_terr3", {31'd0, timeout_err3}, 32'd0);
      check("exp_q_empty", exp_q.size(), 32'd0);
      check("exp3_empty", exp3.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
